score_ctrl: RTL

//  Owns Pac-Man score (4 BCD digits) and lives count; sequences ASCII writes into the

---
 rtl/score_pkg.sv | 28 ++
 rtl/bcd_add4.sv | 40 ++++
 rtl/score_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score/lives controller.
package score_pkg;

  typedef enum logic [3:0] {
    S_INIT0,
    S_INIT1,
    S_INIT2,
    S_INIT3,
    S_INIT4,
    S_IDLE,
    S_ADD,
    S_WR_D0,
    S_WR_D1,
    S_WR_D2,
    S_WR_D3,
    S_WR_LIVES
  } score_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam logic [15:0] SCORE_SAT  = 16'h9999;

  function automatic logic [7:0] bcd_ascii(input bcd_digit_t d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bcd_add4.sv
// Combinational 4-digit packed-BCD adder; saturation is left to the caller.
module bcd_add4
  import score_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o,
  output logic        carry_o,
  output logic        thousands_inc_o
);

  logic [4:0]  carry;
  logic [15:0] sum;

  always_comb begin
    logic [4:0] raw;
    logic [4:0] adj;
    carry    = '0;
    sum      = '0;
    raw      = '0;
    adj      = '0;
    for (int i = 0; i < 4; i++) begin
      raw = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, carry[i]};
      if (raw > 5'd9) begin
        adj          = raw + 5'd6;
        carry[i + 1] = 1'b1;
      end else begin
        adj          = raw;
        carry[i + 1] = 1'b0;
      end
      sum[4*i +: 4] = adj[3:0];
    end
  end

  assign sum_o           = sum;
  assign carry_o         = carry[4];
  // A wrapped thousands digit still counts as an increase; the caller masks it with carry.
  assign thousands_inc_o = carry[4] | (sum[15:12] != a_i[15:12]);

endmodule

// File: rtl/score_ctrl.sv
// Score and lives owner: BCD score accumulation and ASCII writes into the score text RAM.
// Define EXTRA_LIFE_EN to award a life whenever the thousands digit increases.
//
// state      | meaning
// S_INIT0..3 | write '0' to the four score digit cells
// S_INIT4    | write the initial lives digit
// S_IDLE     | wait for a points request or a lost life
// S_ADD      | add captured points to the score (saturating)
// S_WR_D0..3 | write score digits, most significant first
// S_WR_LIVES | write the (already updated) lives digit
module score_ctrl
  import score_pkg::*;
#(
  parameter logic [7:0] SCORE_BASE_ADDR = 8'd7,
  parameter logic [7:0] LIVES_ADDR      = 8'd32,
  parameter int unsigned INIT_LIVES     = 2,
  parameter int unsigned MAX_LIVES      = 9
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        add_valid,
  input  logic [15:0] add_bcd,
  output logic        add_ready,
  input  logic        life_lost,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_data,
  output logic [15:0] score_bcd,
  output logic [3:0]  lives,
  output logic        game_over,
  output logic        busy
);

`ifdef EXTRA_LIFE_EN
  localparam bit EXTRA_LIFE = 1'b1;
`else
  localparam bit EXTRA_LIFE = 1'b0;
`endif

  localparam logic [3:0] INIT_LIVES_V = 4'(INIT_LIVES);
  localparam logic [3:0] MAX_LIVES_V  = 4'(MAX_LIVES);

  score_state_t state_q, state_d;
  logic [15:0]  score_q, score_d;
  logic [15:0]  add_q, add_d;
  logic [3:0]   lives_q, lives_d;
  logic         game_over_q, game_over_d;
  logic         life_pend_q, life_pend_d;

  logic [15:0]  sum;
  logic         sum_carry;
  logic         thousands_inc;
  logic         accept;
  logic         dec_life;

  bcd_add4 u_add (
    .a_i             (score_q),
    .b_i             (add_q),
    .sum_o           (sum),
    .carry_o         (sum_carry),
    .thousands_inc_o (thousands_inc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_INIT0;
      score_q     <= '0;
      add_q       <= '0;
      lives_q     <= INIT_LIVES_V;
      game_over_q <= 1'b0;
      life_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      add_q       <= add_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      life_pend_q <= life_pend_d;
    end
  end

  assign accept = add_valid & add_ready;

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    add_d       = add_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    life_pend_d = life_pend_q | life_lost;
    dec_life    = 1'b0;

    case (state_q)
      S_INIT0: state_d = S_INIT1;
      S_INIT1: state_d = S_INIT2;
      S_INIT2: state_d = S_INIT3;
      S_INIT3: state_d = S_INIT4;
      S_INIT4: state_d = S_IDLE;
      S_IDLE: begin
        if (accept) begin
          add_d   = add_bcd;
          state_d = S_ADD;
        end else if (life_pend_q | life_lost) begin
          dec_life = 1'b1;
          state_d  = S_WR_LIVES;
        end
      end
      S_ADD: begin
        score_d = sum_carry ? SCORE_SAT : sum;
        if (EXTRA_LIFE && thousands_inc && !sum_carry && (lives_q < MAX_LIVES_V)) begin
          lives_d = lives_q + 4'd1;
        end
        state_d = S_WR_D0;
      end
      S_WR_D0: state_d = S_WR_D1;
      S_WR_D1: state_d = S_WR_D2;
      S_WR_D2: state_d = S_WR_D3;
      S_WR_D3: begin
        // A death reported during the add burst is folded into its lives write.
        dec_life = life_pend_q | life_lost;
        state_d  = S_WR_LIVES;
      end
      S_WR_LIVES: state_d = S_IDLE;
      default:    state_d = S_INIT0;
    endcase

    if (dec_life) begin
      life_pend_d = 1'b0;
      if (lives_q != 4'd0) begin
        lives_d = lives_q - 4'd1;
      end
      if (lives_q <= 4'd1) begin
        game_over_d = 1'b1;
      end
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    case (state_q)
      S_INIT0, S_INIT1, S_INIT2, S_INIT3: begin
        ram_we   = 1'b1;
        ram_addr = SCORE_BASE_ADDR + {6'd0, 2'(state_q - S_INIT0)};
        ram_data = ASCII_ZERO;
      end
      S_INIT4: begin
        ram_we   = 1'b1;
        ram_addr = LIVES_ADDR;
        ram_data = bcd_ascii(INIT_LIVES_V);
      end
      S_WR_D0: begin
        ram_we   = 1'b1;
        ram_addr = SCORE_BASE_ADDR;
        ram_data = bcd_ascii(score_q[15:12]);
      end
      S_WR_D1: begin
        ram_we   = 1'b1;
        ram_addr = SCORE_BASE_ADDR + 8'd1;
        ram_data = bcd_ascii(score_q[11:8]);
      end
      S_WR_D2: begin
        ram_we   = 1'b1;
        ram_addr = SCORE_BASE_ADDR + 8'd2;
        ram_data = bcd_ascii(score_q[7:4]);
      end
      S_WR_D3: begin
        ram_we   = 1'b1;
        ram_addr = SCORE_BASE_ADDR + 8'd3;
        ram_data = bcd_ascii(score_q[3:0]);
      end
      S_WR_LIVES: begin
        ram_we   = 1'b1;
        ram_addr = LIVES_ADDR;
        ram_data = bcd_ascii(lives_q);
      end
      default: ;
    endcase
    // No write may escape while reset is held, whatever state it interrupted.
    if (Reset) begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_data = '0;
    end
  end

  assign add_ready = (state_q == S_IDLE) & ~game_over_q & ~Reset;
  assign busy      = (state_q != S_IDLE) | Reset;
  assign score_bcd = score_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule
